// File: rtl/quick_spi_pkg.sv
// rtl/quick_spi_pkg.sv - shared constants and FSM encoding for the quick_spi arbiter
package quick_spi_pkg;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   localparam int DEFAULT_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/quick_spi_arbiter_rr.sv
// rtl/quick_spi_arbiter_rr.sv - combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0]   win_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found      = 1'b0;
      cand       = '0;
      win_onehot = '0;
      win_idx    = '0;
      // The last requester visited is the previous owner, so it ranks lowest.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found            = 1'b1;
            win_onehot[cand] = 1'b1;
            win_idx          = cand;
         end
      end
   end

endmodule

// File: rtl/quick_spi_arbiter.sv
// rtl/quick_spi_arbiter.sv - round-robin sharing of one quick_spi master with a timeout watchdog
module quick_spi_arbiter
   import quick_spi_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int SLAVE_W = 2,
   parameter int OUT_W   = 16,
   parameter int IN_W    = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*SLAVE_W-1:0] req_slave,
   input  logic [NUM_REQ-1:0]         req_op,
   input  logic [NUM_REQ*OUT_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic [IN_W-1:0]            rdata,
   output logic                       err,
   output logic                       busy,
   output logic                       spi_enable,
   output logic                       spi_start_transaction,
   output logic [SLAVE_W-1:0]         spi_slave,
   output logic                       spi_operation,
   output logic [OUT_W-1:0]           spi_outgoing_data,
   input  logic                       spi_end_of_transaction,
   input  logic [IN_W-1:0]            spi_incoming_data
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     owner_idx;
   logic [NUM_REQ-1:0]   owner_onehot;
   logic [WD_W-1:0]      wd;
   logic                 wd_last;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [IDX_W-1:0]     win_idx;
   logic [SLAVE_W-1:0]   sel_slave;
   logic                 sel_op;
   logic [OUT_W-1:0]     sel_wdata;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req        (req),
      .ptr        (ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx)
   );

   always_comb begin
      sel_slave = '0;
      sel_op    = OP_WRITE;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_onehot[i]) begin
            sel_slave = req_slave[i*SLAVE_W +: SLAVE_W];
            sel_op    = req_op[i];
            sel_wdata = req_wdata[i*OUT_W +: OUT_W];
         end
      end
   end

   assign wd_last = (wd == WD_LAST);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|req) state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (spi_end_of_transaction || wd_last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr                   <= IDX_W'(NUM_REQ - 1);
         owner_idx             <= '0;
         owner_onehot          <= '0;
         wd                    <= '0;
         gnt                   <= '0;
         done                  <= '0;
         rdata                 <= '0;
         err                   <= 1'b0;
         busy                  <= 1'b0;
         spi_enable            <= 1'b0;
         spi_start_transaction <= 1'b0;
         spi_slave             <= '0;
         spi_operation         <= 1'b0;
         spi_outgoing_data     <= '0;
      end else begin
         spi_enable            <= 1'b1;
         gnt                   <= '0;
         done                  <= '0;
         err                   <= 1'b0;
         spi_start_transaction <= 1'b0;
         case (state_q)
            ST_IDLE: if (|req) begin
               gnt               <= win_onehot;
               owner_onehot      <= win_onehot;
               owner_idx         <= win_idx;
               spi_slave         <= sel_slave;
               spi_operation     <= sel_op;
               spi_outgoing_data <= sel_wdata;
               busy              <= 1'b1;
            end
            ST_START: begin
               spi_start_transaction <= 1'b1;
               wd                    <= '0;
            end
            // A real end_of_transaction beats the watchdog in the same cycle.
            ST_WAIT: begin
               if (spi_end_of_transaction) begin
                  done <= owner_onehot;
                  if (spi_operation == OP_READ) rdata <= spi_incoming_data;
               end else if (wd_last) begin
                  done <= owner_onehot;
                  err  <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_DONE: begin
               ptr  <= owner_idx;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// tb/tb_quick_spi_arbiter.sv - directed self-checking bench for quick_spi_arbiter
module tb_quick_spi_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [7:0]  req_slave;
   logic [3:0]  req_op;
   logic [63:0] req_wdata;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [7:0]  rdata;
   logic        err;
   logic        busy;
   logic        spi_enable;
   logic        spi_start;
   logic [1:0]  spi_slave;
   logic        spi_operation;
   logic [15:0] spi_outgoing_data;
   logic        spi_eot;
   logic [7:0]  spi_incoming_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   quick_spi_arbiter #(
      .NUM_REQ(4), .SLAVE_W(2), .OUT_W(16), .IN_W(8), .TIMEOUT(16)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .req                    (req),
      .req_slave              (req_slave),
      .req_op                 (req_op),
      .req_wdata              (req_wdata),
      .gnt                    (gnt),
      .done                   (done),
      .rdata                  (rdata),
      .err                    (err),
      .busy                   (busy),
      .spi_enable             (spi_enable),
      .spi_start_transaction  (spi_start),
      .spi_slave              (spi_slave),
      .spi_operation          (spi_operation),
      .spi_outgoing_data      (spi_outgoing_data),
      .spi_end_of_transaction (spi_eot),
      .spi_incoming_data      (spi_incoming_data)
   );

   typedef struct {
      logic [3:0]  req;
      logic [1:0]  slave;
      logic        op;
      logic [15:0] wdata;
      int          delay;
      logic [7:0]  din;
      logic [3:0]  exp_gnt;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive a request whose winner is exp_g, check the grant and the start pulse.
   task automatic start_txn(input logic [3:0] r, input logic [1:0] slv, input logic op,
                            input logic [15:0] wd, input logic [3:0] exp_g);
      int w;
      w = 0;
      for (int i = 0; i < 4; i++) if (exp_g[i]) w = i;
      for (int i = 0; i < 4; i++) begin
         req_slave[i*2 +: 2]   = (i == w) ? slv : ~slv;
         req_wdata[i*16 +: 16] = (i == w) ? wd : ~wd;
         req_op[i]             = (i == w) ? op : ~op;
      end
      req = r;
      @(negedge clk);
      check("gnt", 32'(gnt), 32'(exp_g));
      check("busy_on_gnt", 32'(busy), 32'd1);
      check("start_early", 32'(spi_start), 32'd0);
      req       = '0;
      req_slave = ~req_slave;
      req_wdata = ~req_wdata;
      req_op    = ~req_op;
      @(negedge clk);
      check("start_pulse", 32'(spi_start), 32'd1);
      check("gnt_one_cycle", 32'(gnt), 32'd0);
      check("spi_slave", 32'(spi_slave), 32'(slv));
      check("spi_operation", 32'(spi_operation), 32'(op));
      check("spi_outgoing", 32'(spi_outgoing_data), 32'(wd));
   endtask

   // eot_at: negedge count after the start pulse at which eot is raised (-1 = never).
   task automatic wait_done(input int eot_at, input logic [7:0] din, output int when);
      when = 0;
      spi_incoming_data = din;
      spi_eot = (eot_at == 0);
      for (int c = 1; c <= 40 && when == 0; c++) begin
         @(negedge clk);
         spi_eot = 1'b0;
         if (done != 4'b0) when = c;
         else if (c == eot_at) spi_eot = 1'b1;
      end
      spi_eot = 1'b0;
   endtask

   task automatic run_txn(input vec_t v);
      int when;
      start_txn(v.req, v.slave, v.op, v.wdata, v.exp_gnt);
      wait_done(v.delay, v.din, when);
      check("done_latency", 32'(when), 32'(v.delay + 1));
      check("done", 32'(done), 32'(v.exp_gnt));
      check("err_clear", 32'(err), 32'd0);
      check("rdata", 32'(rdata), 32'(v.exp_rdata));
      check("start_once", 32'(spi_start), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [3:0] order [5];
      logic [3:0] g;
      int when;
      int stray;

      vecs[0] = '{4'b0001, 2'b01, 1'b0, 16'h5A5A, 2, 8'h77, 4'b0001, 8'h00};
      vecs[1] = '{4'b0100, 2'b10, 1'b1, 16'h1234, 0, 8'hCA, 4'b0100, 8'hCA};
      vecs[2] = '{4'b0010, 2'b11, 1'b0, 16'hBEEF, 1, 8'h55, 4'b0010, 8'hCA};
      vecs[3] = '{4'b1010, 2'b00, 1'b1, 16'h0F0F, 3, 8'h3C, 4'b1000, 8'h3C};
      vecs[4] = '{4'b1010, 2'b01, 1'b1, 16'h8001, 0, 8'hA5, 4'b0010, 8'hA5};
      vecs[5] = '{4'b0101, 2'b10, 1'b0, 16'hC3C3, 1, 8'h11, 4'b0100, 8'hA5};
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;

      reset = 1'b1; req = '0; req_slave = '0; req_op = '0; req_wdata = '0;
      spi_eot = 1'b0; spi_incoming_data = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_enable", 32'(spi_enable), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("enable_after_rst", 32'(spi_enable), 32'd1);

      for (int i = 0; i < 5; i++) run_txn(vecs[i]);

      // Stray eot while idle must not complete anything or touch rdata.
      spi_incoming_data = 8'hFF;
      spi_eot = 1'b1;
      @(negedge clk);
      spi_eot = 1'b0;
      check("stray_done", 32'(done), 32'd0);
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_start", 32'(spi_start), 32'd0);
      @(negedge clk);
      check("stray_gnt", 32'(gnt), 32'd0);
      check("stray_rdata", 32'(rdata), 32'hA5);

      // Timeout on a read: done+err 16 cycles after entering WAIT, rdata kept.
      start_txn(4'b0001, 2'b11, 1'b1, 16'h7777, 4'b0001);
      wait_done(-1, 8'hEE, when);
      check("to_latency", 32'(when), 32'd16);
      check("to_done", 32'(done), 32'b0001);
      check("to_err", 32'(err), 32'd1);
      check("to_rdata", 32'(rdata), 32'hA5);
      @(negedge clk);
      check("to_err_pulse", 32'(err), 32'd0);
      check("to_busy", 32'(busy), 32'd0);

      run_txn(vecs[5]);

      // eot on the very cycle the watchdog expires wins.
      start_txn(4'b1001, 2'b01, 1'b1, 16'h4242, 4'b1000);
      wait_done(15, 8'h5E, when);
      check("race_latency", 32'(when), 32'd16);
      check("race_done", 32'(done), 32'b1000);
      check("race_err", 32'(err), 32'd0);
      check("race_rdata", 32'(rdata), 32'h5E);
      @(negedge clk);

      // Reset during WAIT, then fairness from the reset pointer with all requests held.
      start_txn(4'b0010, 2'b10, 1'b0, 16'h9999, 4'b0010);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      check("mid_rst_gnt", 32'(gnt), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_enable", 32'(spi_enable), 32'd0);
      check("mid_rst_start", 32'(spi_start), 32'd0);
      check("mid_rst_slave", 32'(spi_slave), 32'd0);
      check("mid_rst_op", 32'(spi_operation), 32'd0);
      check("mid_rst_wdata", 32'(spi_outgoing_data), 32'd0);
      check("mid_rst_rdata", 32'(rdata), 32'd0);
      reset = 1'b0;

      for (int n = 0; n < 5; n++) begin
         g = '0;
         stray = 0;
         for (int c = 0; c < 10 && g == 4'b0; c++) begin
            @(negedge clk);
            if (done != 4'b0) stray++;
            g = gnt;
         end
         check("fair_stray_done", 32'(stray), 32'd0);
         check("fair_gnt", 32'(g), 32'(order[n]));
         @(negedge clk);
         check("fair_start", 32'(spi_start), 32'd1);
         check("fair_no_gnt_busy", 32'(gnt), 32'd0);
         spi_eot = 1'b1;
         @(negedge clk);
         spi_eot = 1'b0;
         check("fair_done", 32'(done), 32'(order[n]));
         check("fair_no_gnt_done", 32'(gnt), 32'd0);
         @(negedge clk);
         check("fair_busy_clear", 32'(busy), 32'd0);
         check("fair_no_gnt_idle", 32'(gnt), 32'd0);
      end
      req = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/quick_spi_arbiter.md
Name: quick_spi_arbiter

Overview:
- Shares one quick_spi master between NUM_REQ independent requesters.
- Round-robin arbitration; the winner's slave select, operation and outgoing word are latched.
- Sequences one quick_spi transaction per grant, then returns read data with a per-requester done pulse.
- Sits between the register/DMA clients and quick_spi. A timeout watchdog recovers from a missing end_of_transaction.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SLAVE_W, 2, width of quick_spi slave select.
- OUT_W, 16, outgoing word width.
- IN_W, 8, incoming word width.
- TIMEOUT, 4096, WAIT-state cycles before abort (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_slave  in  NUM_REQ*SLAVE_W  slave select per requester, requester i at slice i.
- req_op  in  NUM_REQ  operation per requester, 0=write, 1=read.
- req_wdata  in  NUM_REQ*OUT_W  outgoing word per requester.
- gnt  out  NUM_REQ  one-cycle grant pulse, one-hot.
- done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rdata  out  IN_W  last read result.
- err  out  1  one-cycle pulse coincident with done when the transaction timed out.
- busy  out  1  high from grant until done.
- spi_enable  out  1  to quick_spi enable.
- spi_start_transaction  out  1  to quick_spi start_transaction.
- spi_slave  out  SLAVE_W  to quick_spi slave.
- spi_operation  out  1  to quick_spi operation.
- spi_outgoing_data  out  OUT_W  to quick_spi outgoing_data.
- spi_end_of_transaction  in  1  from quick_spi, one-cycle pulse.
- spi_incoming_data  in  IN_W  from quick_spi incoming_data, valid with end_of_transaction.

Behaviour:
- **Reset values:** all outputs 0, state IDLE, rr pointer = NUM_REQ-1 (requester 0 wins first), watchdog counter 0.
- **Outputs and one-hot rule:** spi_enable=1 in every non-reset cycle. All outputs are registered. gnt and done are never multi-hot.
- **FSM:** IDLE -> START -> WAIT -> DONE -> IDLE.
- **IDLE:**
  - If any req bit is set, select the first set bit searching from pointer+1 modulo NUM_REQ.
  - Latch that requester's slave, op and wdata into spi_slave, spi_operation and spi_outgoing_data.
  - Pulse gnt[winner] on the next cycle, set busy, go START.
  - A req that drops before being sampled in IDLE is treated as withdrawn.
- **START:** spi_start_transaction=1 for exactly one cycle; clear watchdog; go WAIT.
- **WAIT:**
  - On spi_end_of_transaction: if op=read, capture spi_incoming_data into rdata; go DONE.
  - Otherwise increment the watchdog. At TIMEOUT-1, go DONE with the error flag set.
  - end_of_transaction and timeout in the same cycle: end_of_transaction wins, no err.
- **DONE:**
  - Pulse done[owner]; pulse err if flagged.
  - Update pointer = owner, clear busy, go IDLE.
- **rdata:** holds its value until the next successful read. Writes and timeouts leave rdata unchanged.
- **Ignored events:** spi_end_of_transaction outside WAIT is ignored.
- **Latched fields stable:** spi_slave, spi_operation and spi_outgoing_data do not change from START through DONE. req_* changes after grant have no effect on the current transaction.
- **Back-to-back:** a requester still holding req after its done is eligible again, but only after all other pending requesters, by rr order.
- **Latency:**
  - req to gnt: 1 cycle from the IDLE sample.
  - gnt to spi_start_transaction: 1 cycle.
  - end_of_transaction to done: 1 cycle.
  - Minimum idle-to-idle turnaround: 4 cycles plus quick_spi time.
- **Reset mid-transaction:** everything returns to reset values next edge and no done is issued. quick_spi is reset by the same system reset.

Decomposition:
- **quick_spi_pkg:**
  - OP_WRITE=1'b0 and OP_READ=1'b1.
  - FSM state encoding: IDLE, START, WAIT, DONE.
  - Default TIMEOUT constant.
- **rr_arbiter sub-module:**
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner and winner index.
  - Combinational; pointer register kept in the parent.

Test Plan:
- **Single write:** after reset, req=4'b0001, slave=2'b01, op=0, wdata=16'h5A5A -> gnt[0] one cycle later. spi_start_transaction one-cycle pulse next cycle with spi_outgoing_data=16'h5A5A, spi_slave=2'b01. Model returns eot -> done[0] next cycle; rdata unchanged (8'h00).
- **Single read:** req[2], op=1; model returns 8'hCA with eot -> done[2] and rdata=8'hCA on the same cycle. rdata held through a following write.
- **Fairness:** req=4'b1111 held constant -> grant order 0,1,2,3,0; no gnt while busy=1.
- **Timeout:** TIMEOUT=16, model never pulses eot -> done and err pulse together 16 cycles after entering WAIT. rdata unchanged; next request serviced normally.
- **Reset mid-transaction:** assert reset during WAIT -> all outputs 0 next edge, no done. After release, req[3] is granted only after req[0..2], which are also pending.
- **Stray/late eot:** eot pulse in IDLE ignored. eot coinciding with the timeout cycle -> done without err.
